// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM states, grant
// encoding and request address checking.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic GRANT_DATA  = 1'b0;
  localparam logic GRANT_INSTR = 1'b1;

  localparam int CNT_W = 4;

  // A byte address is rejected when it is not word aligned or reaches past the RAM.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 32'd2)) != 32'd0);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM of 32-bit words with a registered read port.
// Read-first: a write in the same cycle returns the previous word on oQ.
module sp_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              iClk,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iD,
  output logic [31:0]       oQ
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  // Storage write and registered read.
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem_q[iAddr] <= iD;
    end
    oQ <= mem_q[iAddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder serving the data and instruction-fetch ports from one
// shared RAM with a programmable number of wait states per access.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iMemAddr,
  input  logic [31:0] iMemData,
  output logic [31:0] oMemData,
  output logic        oMemDone,
  input  logic        iInstrRead,
  input  logic [31:0] iInstrAddr,
  output logic [31:0] oInstr,
  output logic        oInstrDone,
  output logic        oErr,
  output logic        oBusy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              mem_done_q, instr_done_q, err_out_q;
  logic [31:0]       mem_data_q, instr_q;

  logic              commit_s;
  logic              mem_req_s, instr_req_s;
  logic              mem_err_s, instr_err_s;
  logic              rd_resp_s;
  logic              ram_we_s;
  logic [31:0]       ram_q_s;

  assign mem_req_s   = iMemRead | iMemWrite;
  assign instr_req_s = iInstrRead;
  assign mem_err_s   = (iMemRead & iMemWrite) | addr_err(iMemAddr, ADDR_W);
  assign instr_err_s = addr_err(iInstrAddr, ADDR_W);

  // Arbitration, request latching and wait-state sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    err_d    = err_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_s || instr_req_s) begin
          // Priority only rotates when both ports contend.
          if (mem_req_s && instr_req_s) begin
            gnt_d  = ~last_q;
            last_d = ~last_q;
          end else begin
            gnt_d = instr_req_s ? GRANT_INSTR : GRANT_DATA;
          end
          if (gnt_d == GRANT_DATA) begin
            wr_d    = iMemWrite;
            err_d   = mem_err_s;
            word_d  = iMemAddr[ADDR_W+1:2];
            wdata_d = iMemData;
          end else begin
            wr_d    = 1'b0;
            err_d   = instr_err_s;
            word_d  = iInstrAddr[ADDR_W+1:2];
          end
          cnt_d = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            commit_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = RESP;
          commit_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The RAM is addressed from the next-state latch so a zero-wait access
  // commits on the grant edge itself.
  assign ram_we_s = commit_s & wr_d & ~err_d & ~iRst;

  sp_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .iClk (iClk),
    .iWe  (ram_we_s),
    .iAddr(word_d),
    .iD   (wdata_d),
    .oQ   (ram_q_s)
  );

  // FSM, request latch, done pulses and output-holding registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= GRANT_DATA;
      gnt_q        <= GRANT_DATA;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      word_q       <= '0;
      wdata_q      <= 32'd0;
      mem_done_q   <= 1'b0;
      instr_done_q <= 1'b0;
      err_out_q    <= 1'b0;
      mem_data_q   <= 32'd0;
      instr_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      mem_done_q   <= commit_s & (gnt_d == GRANT_DATA);
      instr_done_q <= commit_s & (gnt_d == GRANT_INSTR);
      err_out_q    <= commit_s & err_d;
      // Read data lives in the RAM output during RESP; capture it as RESP ends.
      if (rd_resp_s && (gnt_q == GRANT_DATA)) begin
        mem_data_q <= ram_q_s;
      end
      if (rd_resp_s && (gnt_q == GRANT_INSTR)) begin
        instr_q <= ram_q_s;
      end
    end
  end

  assign rd_resp_s  = (state_q == RESP) & ~err_q & ~wr_q;
  assign oMemData   = (rd_resp_s && (gnt_q == GRANT_DATA))  ? ram_q_s : mem_data_q;
  assign oInstr     = (rd_resp_s && (gnt_q == GRANT_INSTR)) ? ram_q_s : instr_q;
  assign oMemDone   = mem_done_q;
  assign oInstrDone = instr_done_q;
  assign oErr       = err_out_q;
  assign oBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states and
// one with zero wait states, directed vectors with hand-computed results.
module tb_mem_responder;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mr [2];
  logic        mw [2];
  logic        ir [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [31:0] ia [2];
  logic [31:0] omd [2];
  logic [31:0] oin [2];
  logic        omdone [2];
  logic        oidone [2];
  logic        oerr [2];
  logic        obusy [2];

  logic [31:0] hold_md [2];
  logic [31:0] hold_in [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc;
  int          checks;
  int          errors;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut_w2 (
    .iClk(clk), .iRst(rst),
    .iMemRead(mr[0]), .iMemWrite(mw[0]), .iMemAddr(ma[0]), .iMemData(md[0]),
    .oMemData(omd[0]), .oMemDone(omdone[0]),
    .iInstrRead(ir[0]), .iInstrAddr(ia[0]), .oInstr(oin[0]), .oInstrDone(oidone[0]),
    .oErr(oerr[0]), .oBusy(obusy[0])
  );

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut_w0 (
    .iClk(clk), .iRst(rst),
    .iMemRead(mr[1]), .iMemWrite(mw[1]), .iMemAddr(ma[1]), .iMemData(md[1]),
    .oMemData(omd[1]), .oMemDone(omdone[1]),
    .iInstrRead(ir[1]), .iInstrAddr(ia[1]), .oInstr(oin[1]), .oInstrDone(oidone[1]),
    .oErr(oerr[1]), .oBusy(obusy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (omdone[d] || oidone[d]) begin
          chk("single_done", 32'(omdone[d] & oidone[d]), 32'd0);
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
          end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
          end
          if (!have) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            chk("done_port", 32'(oidone[d]), 32'(e.port));
            chk("latency", 32'(cyc), 32'(e.cyc));
            chk("err", 32'(oerr[d]), 32'(e.err));
            chk("busy_in_resp", 32'(obusy[d]), 32'd1);
            if (e.port) chk("instr_data", oin[d], e.data);
            else        chk("mem_data", omd[d], e.data);
          end
        end
      end
    end
  end

  task automatic wait_done(input int d, input bit port);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = port ? oidone[d] : omdone[d];
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  // Issue one request at a negedge with the DUT idle and wait for its done.
  task automatic req(input int d, input bit port, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input bit eerr, input logic [31:0] rdval);
    exp_t e;
    e.port = port;
    e.err  = eerr;
    e.cyc  = cyc + 1 + wc(d);
    if (!port) begin
      if (rd && !wr && !eerr) hold_md[d] = rdval;
      e.data = hold_md[d];
      mr[d] = rd; mw[d] = wr; ma[d] = addr; md[d] = wdata;
    end else begin
      if (!eerr) hold_in[d] = rdval;
      e.data = hold_in[d];
      ir[d] = 1'b1; ia[d] = addr;
    end
    push(d, e);
    wait_done(d, port);
    mr[d] = 1'b0; mw[d] = 1'b0; ir[d] = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(obusy[d]), 32'd0);
  endtask

  // Both ports request in the same cycle on the two-wait-state instance.
  task automatic conflict(input bit instr_first, input logic [31:0] iaddr,
                          input logic [31:0] idata, input logic [31:0] maddr,
                          input logic [31:0] mdata);
    exp_t ei;
    exp_t em;
    ei.port = 1'b1; ei.err = 1'b0; ei.data = idata;
    em.port = 1'b0; em.err = 1'b0; em.data = mdata;
    ei.cyc = instr_first ? cyc + 3 : cyc + 7;
    em.cyc = instr_first ? cyc + 7 : cyc + 3;
    hold_in[0] = idata;
    hold_md[0] = mdata;
    if (instr_first) begin push(0, ei); push(0, em); end
    else begin push(0, em); push(0, ei); end
    ir[0] = 1'b1; ia[0] = iaddr;
    mr[0] = 1'b1; ma[0] = maddr;
    if (instr_first) begin
      wait_done(0, 1'b1); ir[0] = 1'b0;
      wait_done(0, 1'b0); mr[0] = 1'b0;
    end else begin
      wait_done(0, 1'b0); mr[0] = 1'b0;
      wait_done(0, 1'b1); ir[0] = 1'b0;
    end
    @(negedge clk);
    chk("busy_after_conflict", 32'(obusy[0]), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 1'b0; mw[d] = 1'b0; ir[d] = 1'b0;
      ma[d] = 32'd0; md[d] = 32'd0; ia[d] = 32'd0;
      hold_md[d] = 32'd0; hold_in[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_memdata", omd[d], 32'd0);
      chk("rst_instr", oin[d], 32'd0);
      chk("rst_flags", {28'd0, omdone[d], oidone[d], oerr[d], obusy[d]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Write then read back with two wait states.
    req(0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    req(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);

    // Contention: instruction wins first, data wins the next one.
    req(0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h11111111, 1'b0, 32'd0);
    req(0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h22222222, 1'b0, 32'd0);
    conflict(1'b1, 32'h4, 32'h11111111, 32'h8, 32'h22222222);
    conflict(1'b0, 32'h8, 32'h22222222, 32'h4, 32'h11111111);

    // Rejected requests take full latency and touch nothing.
    req(0, 1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 1'b1, 32'd0);
    req(0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 1'b1, 32'd0);
    req(0, 1'b0, 1'b1, 1'b0, 32'h800, 32'd0, 1'b1, 32'd0);
    req(0, 1'b1, 1'b0, 1'b0, 32'h2, 32'd0, 1'b1, 32'd0);
    req(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);

    // Read data holds across a later write and fetch.
    req(0, 1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'd0);
    req(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 1'b0, 32'hCAFEF00D);
    req(0, 1'b0, 1'b0, 1'b1, 32'h34, 32'h00000055, 1'b0, 32'd0);
    req(0, 1'b1, 1'b0, 1'b0, 32'h4, 32'd0, 1'b0, 32'h11111111);
    chk("hold_memdata", omd[0], 32'hCAFEF00D);

    // Zero wait states: preload then fetch.
    req(1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 32'd0);
    req(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h12345678);
    req(1, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'h12345678);

    // Reset in the middle of a write drops it.
    req(0, 1'b0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'd0);
    mw[0] = 1'b1; ma[0] = 32'h20; md[0] = 32'h0BADF00D;
    @(negedge clk);
    chk("busy_in_wait", 32'(obusy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_memdata", omd[0], 32'd0);
    chk("midrst_instr", oin[0], 32'd0);
    chk("midrst_flags", {28'd0, omdone[0], oidone[0], oerr[0], obusy[0]}, 32'd0);
    mw[0] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      hold_md[d] = 32'd0;
      hold_in[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_rst", 32'(obusy[0]), 32'd0);
    req(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'hA5A5A5A5);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's data port and instruction-fetch port.
- Both ports are served from one shared, word-organised synchronous RAM.
- Latency is programmable in wait states.
- Each port has its own done pulse, so the processor's multi-cycle control can stall on memory.

Parameters:
- ADDR_W, 9: word-index width; RAM holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2: extra wait states per access, legal range 0..15.

Ports:
- iClk  in  1  system clock, all state changes on rising edge
- iRst  in  1  asynchronous, active-high reset
- iMemRead  in  1  data-port read request, level, held until oMemDone
- iMemWrite  in  1  data-port write request, level, held until oMemDone
- iMemAddr  in  32  data-port byte address
- iMemData  in  32  data-port write data
- oMemData  out  32  data-port read data; valid while oMemDone=1, held until next data read completes
- oMemDone  out  1  one-cycle data-port completion pulse
- iInstrRead  in  1  fetch request, level, held until oInstrDone
- iInstrAddr  in  32  fetch byte address
- oInstr  out  32  fetched word; valid while oInstrDone=1, held until next fetch completes
- oInstrDone  out  1  one-cycle fetch completion pulse
- oErr  out  1  pulses with the done pulse when the request was rejected
- oBusy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state, including mid-access):
  - FSM goes to IDLE; wait counter = 0; lastGrant = DATA.
  - oMemData, oInstr = 0; oMemDone, oInstrDone, oErr, oBusy = 0.
  - RAM contents are not cleared; an in-flight write that has not reached its commit edge is dropped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Requests are sampled on each edge.
  - If one port requests, it is granted.
  - If both request, the port not in lastGrant is granted, then lastGrant is updated.
  - On grant, latch port, op, address, write data and error status; load counter = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: decrement counter each cycle; when the counter is 1, the next state is RESP.
- Transition into RESP (single commit edge):
  - Write: RAM[word] <= latched data.
  - Read: granted port's output register <= RAM[word], read-after-write coherent.
- RESP (exactly one cycle):
  - Granted port's done = 1; oErr = latched error; next state IDLE.
  - The requester drops its request on the edge ending RESP, so IDLE never resamples a completed request.
- Latency: done is high exactly WAIT_CYCLES+1 cycles after the edge that granted the request.
- Word index = addr[ADDR_W+1:2].
- Error cases:
  - addr[1:0] != 0, or any addr bit above ADDR_W+1 set.
  - iMemRead and iMemWrite both high.
- On error:
  - No RAM access and no output-register update.
  - Full latency is still taken; done pulses with oErr=1.
- The instruction port is read-only; it has no write path.
- A request dropped early by the requester (protocol violation) does not abort the access; done still pulses.
- At most one done pulse per cycle; oMemDone and oInstrDone are never high together.

Decomposition:
- Package mem_pkg:
  - State enum {IDLE, WAIT, RESP}.
  - Grant encoding GRANT_DATA=0, GRANT_INSTR=1.
  - Counter width constant CNT_W=4.
- Sub-module sp_ram:
  - Single-port synchronous RAM, 32-bit words, 2**ADDR_W deep.
  - Ports iClk, iWe, iAddr, iD, oQ; registered read.
  - The responder's output-holding registers sit outside it.

Test Plan:
1. Write, W=2: iMemWrite=1, iMemAddr=0x10, iMemData=0xDEADBEEF -> oMemDone high exactly 3 cycles after grant, oErr=0; subsequent read of 0x10 returns 0xDEADBEEF with the same latency.
2. Zero wait states: WAIT_CYCLES=0, fetch at 0x0 preloaded 0x12345678 -> oInstrDone and oInstr=0x12345678 in the cycle after the grant edge; oBusy high for exactly that cycle.
3. Simultaneous requests: iInstrRead at 0x4 and iMemRead at 0x8 asserted in the same cycle after reset -> instruction served first, then data. Swap priority on the next conflict -> data served first.
4. Errors:
   - iMemAddr=0x13 (misaligned) -> oMemDone+oErr pulse after full latency; RAM and oMemData unchanged.
   - iMemRead=iMemWrite=1 -> same error response.
   - Address 0x800 with ADDR_W=9 -> same error response.
5. Reset mid-op: assert iRst during WAIT of a write to 0x20 -> all outputs 0, state IDLE, no done pulse; RAM[0x20] retains its old value; a new request after release completes normally.
6. Hold behaviour: after a read returns 0xCAFEF00D, do a write then a fetch -> oMemData stays 0xCAFEF00D throughout.
